// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants: opcodes, funct7 codes, SYSTEM words and formats.
package rv32i_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;  // SUB / SRA / SRAI
  localparam logic [6:0] F7_MULDIV = 7'b0000001;  // M extension

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

endpackage

// File: rtl/rv32i_decoder_if.sv
// Fetch-to-decode bus: stage enable and instruction in, registered decode out.
interface rv32i_decoder_if;
  logic        clk_en;
  logic [31:0] i_instruction;
  logic [6:0]  o_opcode;
  logic [7:0]  o_funct7;
  logic [2:0]  o_funct3;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic [4:0]  o_rd;
  logic [31:0] o_imm;
  logic        o_valid;

  modport master (
    output clk_en, i_instruction,
    input  o_opcode, o_funct7, o_funct3, o_rs1, o_rs2, o_rd, o_imm, o_valid
  );

  modport slave (
    input  clk_en, i_instruction,
    output o_opcode, o_funct7, o_funct3, o_rs1, o_rs2, o_rd, o_imm, o_valid
  );
endinterface

// File: rtl/rv32i_imm_gen.sv
// Combinational immediate generator: instruction word + format -> sign-extended immediate.
module rv32i_imm_gen
  import rv32i_pkg::*;
(
  input  logic [31:0] instruction,
  input  fmt_e        fmt,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for each encoding format.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instruction[31]}}, instruction[31:20]};
      FMT_S: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      FMT_B: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
      FMT_U: imm = {instruction[31:12], 12'h000};
      FMT_J: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_decoder.sv
// Registered RV32I decoder: one-cycle split of an instruction word into fields,
// immediate and a legality flag. Optional macro DECODE_M_EXT_EN accepts the
// MUL/DIV family (OP with funct7 0000001) as legal.
module rv32i_decoder
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  rv32i_decoder_if.slave bus
);

  logic [XLEN-1:0] inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_shift_imm;
  logic            muldiv_ok;
  fmt_e            fmt;

  logic [7:0]      funct7_next;
  logic [2:0]      funct3_next;
  logic [4:0]      rs1_next, rs2_next, rd_next;
  logic [XLEN-1:0] imm_next;
  logic            valid_next;

  logic [6:0]      opcode_reg;
  logic [7:0]      funct7_reg;
  logic [2:0]      funct3_reg;
  logic [4:0]      rs1_reg, rs2_reg, rd_reg;
  logic [XLEN-1:0] imm_reg;
  logic            valid_reg;

  assign inst         = bus.i_instruction;
  assign opcode       = inst[6:0];
  assign funct3       = inst[14:12];
  assign funct7       = inst[31:25];
  assign is_shift_imm = (opcode == OPC_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

`ifdef DECODE_M_EXT_EN
  assign muldiv_ok = (funct7 == F7_MULDIV);
`else
  assign muldiv_ok = 1'b0;
`endif

  // Classify the opcode into an encoding format; unknown opcodes fall back to R.
  always_comb begin
    fmt = FMT_R;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM: fmt = FMT_I;
      OPC_STORE:                fmt = FMT_S;
      OPC_BRANCH:               fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:       fmt = FMT_U;
      OPC_JAL:                  fmt = FMT_J;
      default:                  fmt = FMT_R;
    endcase
  end

  // Zero the fields a format does not encode; shift-immediates keep funct7.
  always_comb begin
    rs1_next    = inst[19:15];
    rs2_next    = inst[24:20];
    rd_next     = inst[11:7];
    funct3_next = funct3;
    funct7_next = {1'b0, funct7};
    case (fmt)
      FMT_I: begin
        rs2_next = '0;
        if (!is_shift_imm) funct7_next = '0;
      end
      FMT_S, FMT_B: begin
        rd_next     = '0;
        funct7_next = '0;
      end
      FMT_U, FMT_J: begin
        rs1_next    = '0;
        rs2_next    = '0;
        funct3_next = '0;
        funct7_next = '0;
      end
      default: ;
    endcase
  end

  // Legality check against the base ISA (plus M when enabled).
  always_comb begin
    valid_next = 1'b0;
    if (inst[1:0] == 2'b11) begin
      case (opcode)
        OPC_LOAD:   valid_next = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        OPC_STORE:  valid_next = (funct3[2] == 1'b0) && (funct3 != 3'b011);
        OPC_BRANCH: valid_next = (funct3 != 3'b010) && (funct3 != 3'b011);
        OPC_JALR:   valid_next = (funct3 == 3'b000);
        OPC_OP_IMM: begin
          case (funct3)
            3'b001:  valid_next = (funct7 == F7_BASE);
            3'b101:  valid_next = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            default: valid_next = 1'b1;
          endcase
        end
        OPC_OP: valid_next = (funct7 == F7_BASE)
                          || ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)))
                          || muldiv_ok;
        OPC_SYSTEM: valid_next = (inst == INST_ECALL) || (inst == INST_EBREAK);
        OPC_MISC_MEM, OPC_LUI, OPC_AUIPC, OPC_JAL: valid_next = 1'b1;
        default: valid_next = 1'b0;
      endcase
    end
  end

  rv32i_imm_gen u_imm_gen (
    .instruction (inst),
    .fmt         (fmt),
    .imm         (imm_next)
  );

  // Output register: cleared by reset, loaded only on enabled edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode_reg <= '0;
      funct7_reg <= '0;
      funct3_reg <= '0;
      rs1_reg    <= '0;
      rs2_reg    <= '0;
      rd_reg     <= '0;
      imm_reg    <= '0;
      valid_reg  <= 1'b0;
    end else if (bus.clk_en) begin
      opcode_reg <= opcode;
      funct7_reg <= funct7_next;
      funct3_reg <= funct3_next;
      rs1_reg    <= rs1_next;
      rs2_reg    <= rs2_next;
      rd_reg     <= rd_next;
      imm_reg    <= imm_next;
      valid_reg  <= valid_next;
    end
  end

  assign bus.o_opcode = opcode_reg;
  assign bus.o_funct7 = funct7_reg;
  assign bus.o_funct3 = funct3_reg;
  assign bus.o_rs1    = rs1_reg;
  assign bus.o_rs2    = rs2_reg;
  assign bus.o_rd     = rd_reg;
  assign bus.o_imm    = imm_reg;
  assign bus.o_valid  = valid_reg;

endmodule

// File: tb/tb_rv32i_decoder.sv
// Bench for rv32i_decoder: directed cases plus randomized words against a
// rule-level reference model. Honours DECODE_M_EXT_EN like the design.
module tb_rv32i_decoder;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [7:0]  funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        valid;
  } dec_t;

`ifdef DECODE_M_EXT_EN
  localparam bit M_EXT = 1'b1;
`else
  localparam bit M_EXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  dec_t last_exp = '0;

  rv32i_decoder_if bus ();

  rv32i_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic dec_t observed();
    dec_t d;
    d.opcode = bus.o_opcode;
    d.funct7 = bus.o_funct7;
    d.funct3 = bus.o_funct3;
    d.rs1    = bus.o_rs1;
    d.rs2    = bus.o_rs2;
    d.rd     = bus.o_rd;
    d.imm    = bus.o_imm;
    d.valid  = bus.o_valid;
    return d;
  endfunction

  // Reference: decide which fields exist for the opcode, build the immediate
  // with signed arithmetic on its bit groups, and apply the legality tables.
  function automatic dec_t ref_decode(input logic [31:0] w);
    dec_t       d;
    int         op, f3, f7;
    bit         has_rs1, has_rs2, has_rd, has_f3, has_f7;
    logic [31:0] imm;
    bit         legal;
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    has_rs1 = 1; has_rs2 = 1; has_rd = 1; has_f3 = 1; has_f7 = 1;
    imm = 32'd0;
    if (op inside {7'h03, 7'h13, 7'h67, 7'h73, 7'h0F}) begin
      has_rs2 = 0;
      has_f7  = (op == 7'h13) && (f3 inside {1, 5});
      imm = 32'(int'(w[31:20]) - (w[31] ? 4096 : 0));
    end else if (op == 7'h23) begin
      has_rd = 0; has_f7 = 0;
      imm = 32'(int'(w[31:25]) * 32 + int'(w[11:7]) - (w[31] ? 4096 : 0));
    end else if (op == 7'h63) begin
      has_rd = 0; has_f7 = 0;
      imm = 32'(int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2
                - (w[31] ? 4096 : 0));
    end else if (op inside {7'h37, 7'h17}) begin
      has_rs1 = 0; has_rs2 = 0; has_f3 = 0; has_f7 = 0;
      imm = {w[31:12], 12'h000};
    end else if (op == 7'h6F) begin
      has_rs1 = 0; has_rs2 = 0; has_f3 = 0; has_f7 = 0;
      imm = 32'(int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2
                - (w[31] ? (1 << 20) : 0));
    end
    case (op)
      7'h03: legal = f3 inside {0, 1, 2, 4, 5};
      7'h23: legal = f3 inside {0, 1, 2};
      7'h63: legal = !(f3 inside {2, 3});
      7'h67: legal = (f3 == 0);
      7'h13: legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {0, 32}) : 1'b1;
      7'h33: legal = (f7 == 0) || (f7 == 32 && f3 inside {0, 5}) || (M_EXT && f7 == 1);
      7'h73: legal = (w == 32'h0000_0073) || (w == 32'h0010_0073);
      7'h0F, 7'h37, 7'h17, 7'h6F: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    d.opcode = w[6:0];
    d.funct7 = has_f7  ? {1'b0, w[31:25]} : 8'd0;
    d.funct3 = has_f3  ? w[14:12] : 3'd0;
    d.rs1    = has_rs1 ? w[19:15] : 5'd0;
    d.rs2    = has_rs2 ? w[24:20] : 5'd0;
    d.rd     = has_rd  ? w[11:7]  : 5'd0;
    d.imm    = imm;
    d.valid  = legal && (w[1:0] == 2'b11);
    return d;
  endfunction

  // Drive one word between edges, take one rising edge, settle, log.
  task automatic apply(input logic [31:0] w, input logic en);
    @(negedge clk);
    bus.i_instruction = w;
    bus.clk_en        = en;
    @(posedge clk);
    #1;
    $display("txn inst=%08h en=%0d -> opc=%02h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%02h imm=%08h valid=%0d",
             w, en, bus.o_opcode, bus.o_rd, bus.o_rs1, bus.o_rs2, bus.o_funct3,
             bus.o_funct7, bus.o_imm, bus.o_valid);
  endtask

  task automatic test_reset();
    dec_t got;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(32'h0050_0093, 1'b1);
      got = observed();
      checks++;
      if (got !== dec_t'('0)) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got=%h exp=%h", i, got, dec_t'('0));
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== dec_t'('0)) begin
      errors++;
      $display("FAIL reset_release got=%h exp=%h", got, dec_t'('0));
    end
  endtask

  task automatic test_directed();
    dec_t got, exp;
    apply(32'h0050_0093, 1'b1);  // addi x1,x0,5
    got = observed();
    exp = '{opcode: 7'h13, funct7: 8'h00, funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd1,
            imm: 32'h0000_0005, valid: 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL addi got=%h exp=%h", got, exp); end

    apply(32'h0020_A423, 1'b1);  // sw x2,8(x1)
    got = observed();
    exp = '{opcode: 7'h23, funct7: 8'h00, funct3: 3'd2, rs1: 5'd1, rs2: 5'd2, rd: 5'd0,
            imm: 32'h0000_0008, valid: 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL sw got=%h exp=%h", got, exp); end

    apply(32'hFE00_0EE3, 1'b1);  // beq x0,x0,-4
    got = observed();
    exp = '{opcode: 7'h63, funct7: 8'h00, funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
            imm: 32'hFFFF_FFFC, valid: 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL beq got=%h exp=%h", got, exp); end

    apply(32'h1234_52B7, 1'b1);  // lui x5,0x12345
    got = observed();
    exp = '{opcode: 7'h37, funct7: 8'h00, funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd5,
            imm: 32'h1234_5000, valid: 1'b1};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL lui got=%h exp=%h", got, exp); end
    last_exp = exp;
  endtask

  task automatic test_invalid();
    dec_t got, exp;
    apply(32'h0000_0000, 1'b1);
    got = observed();
    exp = '0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL zero_word got=%h exp=%h", got, exp); end

    apply(32'h0000_B003, 1'b1);  // LOAD funct3 011
    got = observed();
    exp = '{opcode: 7'h03, funct7: 8'h00, funct3: 3'd3, rs1: 5'd1, rs2: 5'd0, rd: 5'd0,
            imm: 32'h0000_0000, valid: 1'b0};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL load_f3_011 got=%h exp=%h", got, exp); end

    apply(32'h0020_0073, 1'b1);  // SYSTEM, neither ECALL nor EBREAK
    got = observed();
    checks++;
    if (got.valid !== 1'b0) begin
      errors++; $display("FAIL system_other valid got=%0d exp=0", got.valid);
    end

    apply(32'h0010_0073, 1'b1);  // EBREAK
    got = observed();
    checks++;
    if (got.valid !== 1'b1) begin
      errors++; $display("FAIL ebreak valid got=%0d exp=1", got.valid);
    end
    last_exp = got.valid ? ref_decode(32'h0010_0073) : last_exp;
  endtask

  task automatic test_m_ext();
    dec_t got, exp;
    apply(32'h0220_81B3, 1'b1);  // mul x3,x1,x2
    got = observed();
    exp = '{opcode: 7'h33, funct7: 8'h01, funct3: 3'd0, rs1: 5'd1, rs2: 5'd2, rd: 5'd3,
            imm: 32'h0000_0000, valid: M_EXT};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mul got=%h exp=%h", got, exp); end
    last_exp = exp;
  endtask

  task automatic test_clk_en_hold();
    dec_t got;
    apply(32'h0050_0093, 1'b1);
    last_exp = ref_decode(32'h0050_0093);
    for (int i = 0; i < 3; i++) begin
      apply($urandom, 1'b0);
      got = observed();
      checks++;
      if (got !== last_exp) begin
        errors++;
        $display("FAIL clk_en_hold step %0d got=%h exp=%h", i, got, last_exp);
      end
    end
  endtask

  function automatic logic [31:0] random_word();
    logic [6:0]  ops [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                             7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [6:0]  f7s [4]  = '{7'h00, 7'h20, 7'h01, 7'h7F};
    logic [31:0] w;
    int          pick;
    w    = $urandom;
    pick = $urandom_range(0, 19);
    if (pick < 14) w[6:0] = ops[$urandom_range(0, 10)];
    if ($urandom_range(0, 3) != 0) w[31:25] = f7s[$urandom_range(0, 3)];
    if (pick == 15) w = ($urandom_range(0, 1) != 0) ? 32'h0000_0073 : 32'h0010_0073;
    return w;
  endfunction

  task automatic test_back_to_back();
    dec_t        got;
    logic [31:0] w;
    logic        en;
    for (int i = 0; i < 300; i++) begin
      w  = random_word();
      en = ($urandom_range(0, 4) != 0);
      apply(w, en);
      if (en) last_exp = ref_decode(w);
      got = observed();
      checks++;
      if (got !== last_exp) begin
        errors++;
        $display("FAIL random %0d inst=%08h en=%0d got=%h exp=%h", i, w, en, got, last_exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    dec_t got;
    apply(32'h0020_A423, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    got = observed();
    checks++;
    if (got !== dec_t'('0)) begin
      errors++; $display("FAIL async_reset got=%h exp=%h", got, dec_t'('0));
    end
    @(negedge clk);
    rst = 1'b1;
    apply(32'h1234_52B7, 1'b1);
    got = observed();
    checks++;
    if (got !== ref_decode(32'h1234_52B7)) begin
      errors++; $display("FAIL post_reset got=%h exp=%h", got, ref_decode(32'h1234_52B7));
    end
  endtask

  initial begin
    bus.clk_en        = 1'b0;
    bus.i_instruction = '0;
    test_reset();
    test_directed();
    test_invalid();
    test_m_ext();
    test_clk_en_hold();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv32i_decoder.md
Name: rv32i_decoder

Overview:
- Registered RV32I instruction decoder between the fetch stage and the register file, load/store and ALU logic in the core.
- Splits a 32-bit instruction word into opcode, funct3, funct7, register indices and a sign-extended immediate.
- Flags whether the word is a legal base-ISA instruction; the core halts the PC on an invalid flag.

Parameters:
- XLEN, 32, instruction and immediate width; only 32 is supported.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_en  in  1  stage enable; outputs update only on clock edges where it is high.
- i_instruction  in  32  raw instruction word from fetch.
- o_opcode  out  7  instruction bits [6:0].
- o_funct7  out  8  bit 7 always 0; bits [6:0] = instruction bits [31:25].
- o_funct3  out  3  instruction bits [14:12].
- o_rs1  out  5  source register 1 index.
- o_rs2  out  5  source register 2 index.
- o_rd  out  5  destination register index.
- o_imm  out  32  sign-extended immediate.
- o_valid  out  1  decoded word is a legal instruction.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low. While rst is low, every output is 0, including o_valid.
- Latency: one cycle. On a rising clk edge with clk_en high, all outputs register the decode of i_instruction. With clk_en low, all outputs hold.
- Formats and field rules:
  - R-type: all fields passed through; o_imm = 0.
  - I-type (LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011): o_rs2 = 0. o_funct7 = 0, except OP-IMM shifts (funct3 001/101), which carry bits [31:25]. o_imm = sext(inst[31:20]).
  - S-type (STORE 0100011): o_rd = 0, o_funct7 = 0. o_imm = sext({inst[31:25], inst[11:7]}).
  - B-type (BRANCH 1100011): o_rd = 0, o_funct7 = 0. o_imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - U-type (LUI 0110111, AUIPC 0010111): o_imm = {inst[31:12], 12'h0}. o_rs1, o_rs2, o_funct3 and o_funct7 are 0.
  - J-type (JAL 1101111): o_imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}). o_rs1, o_rs2, o_funct3 and o_funct7 are 0.
  - MISC-MEM (0001111): decoded as I-type.
- o_valid = 1 only when all of the following hold; otherwise 0:
  - inst[1:0] = 11.
  - Opcode is one of the eleven listed above.
  - LOAD funct3 is in {000, 001, 010, 100, 101}.
  - STORE funct3 is in {000, 001, 010}.
  - BRANCH funct3 is not 010 or 011.
  - JALR funct3 = 000.
  - OP-IMM shifts: funct7 = 0000000, or 0100000 for funct3 101 only.
  - OP: funct7 = 0000000 for any funct3, or 0100000 for funct3 000/101.
  - SYSTEM: word is exactly 0x00000073 or 0x00100073.
- When o_valid = 0, the field outputs still carry the format decode, but downstream must ignore them.
- The all-zero word 0x00000000 is always invalid.
- Reset asserted mid-stream clears outputs immediately; the first valid decode appears one enabled edge after rst deasserts.

Optional Feature:
- Macro: DECODE_M_EXT_EN.
- Defined: OP with funct7 = 0000001 (any funct3; MUL/DIV family) decodes as R-type with o_valid = 1.
- Undefined: that encoding gives o_valid = 0.

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_MISC_MEM, OPC_SYSTEM);
  - funct7 constants;
  - typedef enum fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
- One sub-module, rv32i_imm_gen: combinational, maps {instruction, fmt_e} to the 32-bit immediate.

Test Plan:
- Reset: hold rst low, drive 0x00500093 with clk_en = 1 -> all outputs 0 and o_valid = 0 until rst rises.
- addi x1,x0,5 (0x00500093), one enabled edge -> opcode 0010011, rd 1, rs1 0, funct3 0, imm 0x00000005, valid 1.
- sw x2,8(x1) (0x0020A423) -> opcode 0100011, rs1 1, rs2 2, funct3 010, rd 0, imm 0x00000008, valid 1.
- beq x0,x0,-4 (0xFE000EE3) -> imm 0xFFFFFFFC, rd 0, valid 1. Then lui x5,0x12345 (0x123452B7) -> imm 0x12345000, rd 5, valid 1.
- Invalids: 0x00000000 -> valid 0; 0x0000B003 (LOAD funct3 011) -> valid 0.
- mul x3,x1,x2 (0x022081B3) -> valid 1 with DECODE_M_EXT_EN defined, 0 without. clk_en low while the input changes -> outputs hold the previous decode.
